compare_serial: RTL and testbench
=================================

Name: compare_serial

Overview:
- Bit-serial N-bit magnitude comparator.
- Accepts two operands on a start/ready handshake and shifts them MSB-first through a 1-bit compare cell, one bit per clock.
- Reports a one-cycle done_tick with registered gt/eq/lt flags.
- Used where a wide parallel comparator is too costly, or where operands arrive alongside a serial datapath.

Parameters:
- N, 8, operand width in bits; legal range 1..32.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; sampled only when ready=1.
- a  in  N  operand A (unsigned); captured on the accepted start.
- b  in  N  operand B (unsigned); captured on the accepted start.
- ready  out  1  high in idle; block accepts start.
- done_tick  out  1  one-cycle pulse; result valid.
- gt  out  1  a > b for the last completed comparison.
- eq  out  1  a == b for the last completed comparison.
- lt  out  1  a < b for the last completed comparison.

Behaviour:
- Reset (synchronous, active-high):
  - state=idle, ready=1, done_tick=0, gt=eq=lt=0.
  - Shift registers, bit counter and decided flag cleared.
- States:
  - idle:
    - ready=1.
    - start=1 → load a_reg=a, b_reg=b, cnt=N-1, decided=0, res_gt=res_lt=0 → scan.
    - start=0 → stay in idle.
  - scan:
    - ready=0.
    - Cell compares a_reg[N-1], b_reg[N-1].
    - If decided=0 and bits differ: res_gt=cell_gt, res_lt=~cell_gt, decided=1.
    - Shift both registers left by 1; cnt decrements.
    - cnt==0 → done.
  - done:
    - done_tick=1 for exactly this cycle.
    - gt=res_gt, lt=res_lt, eq=~(res_gt|res_lt) are registered on entry to done.
    - Next state is idle.
- Timing, counting the start-accept cycle as 0:
  - scan occupies cycles 1..N.
  - done_tick is high in cycle N+1.
  - ready returns high in cycle N+2.
- Flag rules:
  - gt/eq/lt hold their value from one done_tick to the next.
  - They are not cleared when a new start is accepted.
  - After any done_tick, exactly one of gt/eq/lt is 1.
- start while ready=0 is ignored; no queuing.
- a/b changes after the accept cycle have no effect.
- Reset mid-scan or in done: the next cycle is idle, ready=1, flags=0, and no done_tick is issued.
- N=1: a single scan cycle; done_tick in cycle 2.

Optional Feature:
- Macro: COMPARE_EARLY_EXIT_EN.
- Defined:
  - scan exits to done on the cycle the first differing bit is found, or when cnt==0.
  - For a first difference at bit p (MSB = N-1), done_tick is in cycle N-p+1.
  - Equal operands still take N+1 cycles.
- Undefined:
  - Fixed latency; done_tick is always in cycle N+1.
  - Later bits are scanned but cannot change the decided result.
- Flag values are identical in both builds.

Decomposition:
- Shared package compare_pkg holds:
  - state encoding constants ST_IDLE, ST_SCAN, ST_DONE;
  - counter-width function clog2.
- One natural sub-module: compare_bit_cell.
  - Combinational; 1-bit inputs x, y; outputs bit_gt, bit_eq.
  - Instantiated once on the shift-register MSBs.
- Shift registers, counter, FSM and result registers live in compare_serial.

Test Plan:
1. N=8, a=0xA5, b=0xA5, start in cycle 0 → done_tick in cycle 9 in both builds, eq=1, gt=lt=0, ready=1 in cycle 10.
2. a=0x80, b=0x7F → gt=1; done_tick in cycle 2 with COMPARE_EARLY_EXIT_EN, cycle 9 without.
3. a=0x12, b=0x13 → lt=1, done_tick in cycle 9 in both builds (difference at bit 0); a=0x40, b=0x60 with early exit → lt=1, done_tick in cycle 4.
4. Hold start=1 with changing a/b throughout a scan → only the operands captured on the first accept affect the result, no extra done_tick; flags stay stable until the next done_tick.
5. reset=1 in cycle 4 of the test-1 scan → cycle 5: ready=1, gt=eq=lt=0; no done_tick appears; a following start completes normally.
6. N=1: a=1, b=0 → gt=1, done_tick in cycle 2; then a=0, b=0 → eq=1.

Source files
------------

// File: rtl/compare_pkg.sv
// Shared state encoding and width helper for the bit-serial comparator.
package compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/compare_bit_cell.sv
// One-bit magnitude compare cell: x > y and x == y.
module compare_bit_cell (
  input  logic x,
  input  logic y,
  output logic bit_gt,
  output logic bit_eq
);

  assign bit_gt = x & ~y;
  assign bit_eq = ~(x ^ y);

endmodule

// File: rtl/compare_serial.sv
// Bit-serial N-bit unsigned magnitude comparator, MSB first.
// Define COMPARE_EARLY_EXIT_EN to finish on the first differing bit.
module compare_serial
  import compare_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int unsigned CW = (N > 1) ? clog2(N) : 1;

  state_t          state, state_n;
  logic [N-1:0]    a_reg, a_reg_n;
  logic [N-1:0]    b_reg, b_reg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            decided, decided_n;
  logic            res_gt, res_gt_n;
  logic            res_lt, res_lt_n;
  logic            ready_n, done_n;
  logic            gt_n, eq_n, lt_n;
  logic            cell_gt, cell_eq;
  logic            scan_exit;

  compare_bit_cell u_cell (
    .x      (a_reg[N-1]),
    .y      (b_reg[N-1]),
    .bit_gt (cell_gt),
    .bit_eq (cell_eq)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      decided   <= 1'b0;
      res_gt    <= 1'b0;
      res_lt    <= 1'b0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      state     <= state_n;
      a_reg     <= a_reg_n;
      b_reg     <= b_reg_n;
      cnt       <= cnt_n;
      decided   <= decided_n;
      res_gt    <= res_gt_n;
      res_lt    <= res_lt_n;
      ready     <= ready_n;
      done_tick <= done_n;
      gt        <= gt_n;
      eq        <= eq_n;
      lt        <= lt_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    a_reg_n   = a_reg;
    b_reg_n   = b_reg;
    cnt_n     = cnt;
    decided_n = decided;
    res_gt_n  = res_gt;
    res_lt_n  = res_lt;
    gt_n      = gt;
    eq_n      = eq;
    lt_n      = lt;
    scan_exit = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          a_reg_n   = a;
          b_reg_n   = b;
          cnt_n     = CW'(N - 1);
          decided_n = 1'b0;
          res_gt_n  = 1'b0;
          res_lt_n  = 1'b0;
          state_n   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // First differing bit from the MSB decides; later bits are ignored.
        if (!decided && !cell_eq) begin
          res_gt_n  = cell_gt;
          res_lt_n  = ~cell_gt;
          decided_n = 1'b1;
        end
        a_reg_n = a_reg << 1;
        b_reg_n = b_reg << 1;
        if (cnt != '0) cnt_n = cnt - CW'(1);
`ifdef COMPARE_EARLY_EXIT_EN
        scan_exit = (cnt == '0) || (!decided && !cell_eq);
`else
        scan_exit = (cnt == '0);
`endif
        if (scan_exit) begin
          state_n = ST_DONE;
          gt_n    = res_gt_n;
          lt_n    = res_lt_n;
          eq_n    = ~(res_gt_n | res_lt_n);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    ready_n = (state_n == ST_IDLE);
    done_n  = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_compare_serial.sv
// Self-checking bench for compare_serial (N=8 and N=1 instances).
module tb_compare_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset8, start8;
  logic [7:0] a8, b8;
  logic       ready8, done8, gt8, eq8, lt8;

  logic       reset1, start1;
  logic [0:0] a1, b1;
  logic       ready1, done1, gt1, eq1, lt1;

  compare_serial #(.N(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done_tick(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  compare_serial #(.N(1)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .done_tick(done1), .gt(gt1), .eq(eq1), .lt(lt1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         p;
    logic       gt;
    logic       eq;
    logic       lt;
  } vec_t;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[8];
  logic [2:0] model8;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int lat8(input int p);
`ifdef COMPARE_EARLY_EXIT_EN
    if (p >= 0) return 8 - p + 1;
`endif
    return 9;
  endfunction

  // Drive one N=8 comparison from a negedge; hold=1 keeps start high with junk operands.
  task automatic run8(input vec_t v, input bit hold);
    exp_t e;
    exp_t got;
    int   seen_k;
    int   dones;
    e.flags = {v.gt, v.eq, v.lt};
    e.lat   = lat8(v.p);
    sb.push_back(e);
    check("ready_before_start", int'(ready8), 1);
    a8 = v.a; b8 = v.b; start8 = 1'b1;
    seen_k = 0;
    dones  = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done8) begin
        dones++;
        if (seen_k == 0) begin
          seen_k = k;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            got = sb.pop_front();
            check("done_latency", k, got.lat);
            check("flags_at_done", int'({gt8, eq8, lt8}), int'(got.flags));
            check("ready_low_in_done", int'(ready8), 0);
            model8 = got.flags;
          end
        end
      end else if (seen_k == 0) begin
        check("flags_hold_in_scan", int'({gt8, eq8, lt8}), int'(model8));
        check("ready_low_in_scan", int'(ready8), 0);
      end else if (k == seen_k + 1) begin
        check("ready_after_done", int'(ready8), 1);
        check("flags_hold_after", int'({gt8, eq8, lt8}), int'(model8));
      end
      if (seen_k != 0) start8 = 1'b0;
      else if (hold) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      else start8 = 1'b0;
    end
    if (seen_k == 0) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
    end
    check("done_count", dones, 1);
  endtask

  task automatic run1(input logic va, input logic vb, input logic [2:0] f);
    exp_t e;
    exp_t got;
    int   seen_k;
    e.flags = f;
    e.lat   = 2;
    sb.push_back(e);
    check("n1_ready_before", int'(ready1), 1);
    a1 = va; b1 = vb; start1 = 1'b1;
    seen_k = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1 && seen_k == 0) begin
        seen_k = k;
        got = sb.pop_front();
        check("n1_latency", k, got.lat);
        check("n1_flags", int'({gt1, eq1, lt1}), int'(got.flags));
      end else if (seen_k != 0 && k == seen_k + 1) begin
        check("n1_ready_after", int'(ready1), 1);
      end
    end
    if (seen_k == 0) begin
      check("n1_done_timeout", 0, 1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int dones;
    vec_t v;

    vecs[0] = '{8'hA5, 8'hA5, -1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8'h7F,  7, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 8'h13,  0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h40, 8'h60,  5, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'hFF,  7, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'h00,  7, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, -1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 8'h00,  0, 1'b1, 1'b0, 1'b0};

    reset8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    reset1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0;
    model8 = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready8), 1);
    check("rst_done", int'(done8), 0);
    check("rst_flags", int'({gt8, eq8, lt8}), 0);
    check("n1_rst_ready", int'(ready1), 1);
    check("n1_rst_flags", int'({gt1, eq1, lt1}), 0);
    reset8 = 1'b0; reset1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run8(vecs[i], 1'b0);

    // start held high with changing operands: only the first capture counts
    run8(vecs[3], 1'b1);
    run8(vecs[5], 1'b1);

    // reset in cycle 4 of an A5/A5 scan
    a8 = 8'hA5; b8 = 8'hA5; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    model8 = 3'b000;
    check("midrst_ready", int'(ready8), 1);
    check("midrst_flags", int'({gt8, eq8, lt8}), 0);
    check("midrst_done", int'(done8), 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("midrst_no_done", dones, 0);
    run8(vecs[0], 1'b0);
    v = '{8'h3C, 8'h3D, 0, 1'b0, 1'b0, 1'b1};
    run8(v, 1'b0);

    run1(1'b1, 1'b0, 3'b100);
    run1(1'b0, 1'b0, 3'b010);
    run1(1'b0, 1'b1, 3'b001);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
